// File: rtl/montgomery_exp_seq_if.sv
// Request/response and multiplier-side signals of the Montgomery exponentiation sequencer.
// The slave modport is the sequencer's view; master is the RSA core plus multiplier side.
interface montgomery_exp_seq_if #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EXP_WIDTH = 512,
    parameter int unsigned ELEN_W    = 10
);
    logic                 start;
    logic                 ladder;
    logic [WIDTH-1:0]     in_x;
    logic [EXP_WIDTH-1:0] in_e;
    logic [ELEN_W-1:0]    in_elen;
    logic [WIDTH-1:0]     in_m;
    logic [WIDTH-1:0]     in_rmodm;
    logic [WIDTH-1:0]     in_r2modm;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_done;
    logic [WIDTH-1:0]     mul_result;

    modport slave (
        input  start, ladder, in_x, in_e, in_elen, in_m, in_rmodm, in_r2modm,
        input  mul_done, mul_result,
        output busy, done, result, mul_start, mul_a, mul_b
    );

    modport master (
        output start, ladder, in_x, in_e, in_elen, in_m, in_rmodm, in_r2modm,
        output mul_done, mul_result,
        input  busy, done, result, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/montgomery_exp_seq.sv
// Modular exponentiation sequencer: walks the exponent MSB first and drives an external
// Montgomery multiplier, in square-and-multiply or constant-time ladder mode.
module montgomery_exp_seq #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EXP_WIDTH = 512,
    parameter int unsigned ELEN_W    = 10
) (
    input logic                 clk,
    input logic                 reset,
    montgomery_exp_seq_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StToMont, StSq, StMul, StLd1, StLd2, StFromMont, StDone
    } state_e;

    localparam logic [ELEN_W-1:0] ExpLen = ELEN_W'(EXP_WIDTH);

    state_e               r_state;
    logic                 r_wait;
    logic                 r_ladder;
    logic                 r_zero;
    logic [EXP_WIDTH-1:0] r_e;
    logic [ELEN_W-1:0]    r_idx;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_t;
    logic [WIDTH-1:0]     r_result;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_mul_start;
    logic [WIDTH-1:0]     r_mul_a;
    logic [WIDTH-1:0]     r_mul_b;

    logic [ELEN_W-1:0]    w_elen;
    logic                 w_ebit;
    logic                 w_last;
    logic                 w_mul_state;
    logic [WIDTH-1:0]     w_op_a;
    logic [WIDTH-1:0]     w_op_b;

    assign w_elen = (bus.in_elen > ExpLen) ? ExpLen : bus.in_elen;
    assign w_ebit = |(r_e & (EXP_WIDTH'(1) << r_idx));
    assign w_last = (r_idx == '0);
    assign w_mul_state = (r_state != StIdle) && (r_state != StDone);

    // TO_MONT operands are preloaded into the multiplier registers when start is accepted.
    always_comb begin
        w_op_a = r_mul_a;
        w_op_b = r_mul_b;
        unique case (r_state)
            StSq:       begin w_op_a = r_a; w_op_b = r_a; end
            StMul:      begin w_op_a = r_a; w_op_b = r_b; end
            StLd1:      begin w_op_a = r_a; w_op_b = r_b; end
            StLd2:      begin
                w_op_a = w_ebit ? r_b : r_a;
                w_op_b = w_ebit ? r_b : r_a;
            end
            StFromMont: begin w_op_a = r_a; w_op_b = WIDTH'(1); end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_wait      <= 1'b0;
            r_ladder    <= 1'b0;
            r_zero      <= 1'b0;
            r_e         <= '0;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_t         <= '0;
            r_result    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_start <= 1'b0;
            if (w_mul_state && !r_wait) begin
                r_mul_start <= 1'b1;
                r_mul_a     <= w_op_a;
                r_mul_b     <= w_op_b;
                r_wait      <= 1'b1;
            end
            case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_ladder <= bus.ladder;
                        r_e      <= bus.in_e;
                        r_idx    <= w_elen - ELEN_W'(1);
                        r_zero   <= (w_elen == '0);
                        r_a      <= bus.in_rmodm;
                        r_mul_a  <= bus.in_x;
                        r_mul_b  <= bus.in_r2modm;
                        r_wait   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= StToMont;
                    end
                end
                StToMont: begin
                    if (r_wait && bus.mul_done) begin
                        r_b     <= bus.mul_result;
                        r_wait  <= 1'b0;
                        r_state <= r_zero ? StFromMont : (r_ladder ? StLd1 : StSq);
                    end
                end
                StSq, StMul, StLd2: begin
                    if (r_wait && bus.mul_done) begin
                        r_wait <= 1'b0;
                        if (r_state == StLd2 && w_ebit) begin
                            r_b <= bus.mul_result;
                            r_a <= r_t;
                        end else begin
                            r_a <= bus.mul_result;
                            if (r_state == StLd2) begin
                                r_b <= r_t;
                            end
                        end
                        // A set exponent bit in square-and-multiply inserts the MUL step.
                        if (r_state == StSq && w_ebit) begin
                            r_state <= StMul;
                        end else if (w_last) begin
                            r_state <= StFromMont;
                        end else begin
                            r_idx   <= r_idx - ELEN_W'(1);
                            r_state <= r_ladder ? StLd1 : StSq;
                        end
                    end
                end
                StLd1: begin
                    if (r_wait && bus.mul_done) begin
                        r_t     <= bus.mul_result;
                        r_wait  <= 1'b0;
                        r_state <= StLd2;
                    end
                end
                StFromMont: begin
                    if (r_wait && bus.mul_done) begin
                        r_result <= bus.mul_result;
                        r_wait   <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.mul_start = r_mul_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;
endmodule

// File: tb/tb_montgomery_exp_seq.sv
// Bench for montgomery_exp_seq: 512-bit and 16-bit instances, each served by a behavioural
// Montgomery multiplier; results are compared against plain modular exponentiation.
module tb_montgomery_exp_seq;
    localparam int unsigned W   = 512;
    localparam int unsigned EW  = 512;
    localparam int unsigned LW  = 10;
    localparam int unsigned SW  = 16;
    localparam int unsigned SEW = 16;
    localparam int unsigned SLW = 5;

    typedef logic [1039:0] big_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    montgomery_exp_seq_if #(.WIDTH(W), .EXP_WIDTH(EW), .ELEN_W(LW)) bus_l ();
    montgomery_exp_seq_if #(.WIDTH(SW), .EXP_WIDTH(SEW), .ELEN_W(SLW)) bus_s ();

    montgomery_exp_seq #(.WIDTH(W), .EXP_WIDTH(EW), .ELEN_W(LW)) u_dut_l (
        .clk(clk), .reset(reset), .bus(bus_l.slave)
    );
    montgomery_exp_seq #(.WIDTH(SW), .EXP_WIDTH(SEW), .ELEN_W(SLW)) u_dut_s (
        .clk(clk), .reset(reset), .bus(bus_s.slave)
    );

    int   n_checks = 0;
    int   n_fails = 0;
    int   lat_fixed = 0;
    int   mcnt_l = 0;
    int   mcnt_s = 0;
    big_t mod_l = big_t'(1);
    big_t mod_s = big_t'(1);

    // a*b*2^-w mod m, bit-serial
    function automatic big_t mm(input big_t a, input big_t b, input big_t m, input int w);
        big_t t = '0;
        for (int i = 0; i < w; i++) begin
            if (a[i]) t = t + b;
            if (t[0]) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic big_t mod_exp(input big_t x, input big_t e, input int elen, input big_t m);
        big_t r = big_t'(1) % m;
        for (int i = elen - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * x) % m;
        end
        return r;
    endfunction

    function automatic int popcnt(input big_t e, input int elen);
        int n = 0;
        for (int i = 0; i < elen; i++) n += int'(e[i]);
        return n;
    endfunction

    function automatic big_t rand_big(input int w);
        big_t r = '0;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom();
        r = r & ((big_t'(1) << w) - big_t'(1));
        return r;
    endfunction

    function automatic big_t rand_mod(input int w);
        big_t m = rand_big(w);
        m = m | (big_t'(1) << (w - 1)) | big_t'(1);
        return m;
    endfunction

    // Behavioural multipliers; an in-flight request is dropped when reset is seen.
    always begin
        big_t ma, mb, mr;
        int   lat;
        bit   aborted;
        @(negedge clk);
        if (!reset && bus_l.mul_start === 1'b1) begin
            ma = big_t'(bus_l.mul_a);
            mb = big_t'(bus_l.mul_b);
            mcnt_l++;
            lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 20));
            aborted = 1'b0;
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                mr = mm(ma, mb, mod_l, W);
                bus_l.mul_result = mr[W-1:0];
                bus_l.mul_done = 1'b1;
                @(negedge clk);
                bus_l.mul_done = 1'b0;
            end
        end
    end

    always begin
        big_t ma, mb, mr;
        int   lat;
        bit   aborted;
        @(negedge clk);
        if (!reset && bus_s.mul_start === 1'b1) begin
            ma = big_t'(bus_s.mul_a);
            mb = big_t'(bus_s.mul_b);
            mcnt_s++;
            lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 20));
            aborted = 1'b0;
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                if (reset) begin
                    aborted = 1'b1;
                    break;
                end
            end
            if (!aborted) begin
                mr = mm(ma, mb, mod_s, SW);
                bus_s.mul_result = mr[SW-1:0];
                bus_s.mul_done = 1'b1;
                @(negedge clk);
                bus_s.mul_done = 1'b0;
            end
        end
    end

    task automatic drive_l(input bit ld, input big_t x, input big_t e, input int elen,
                           input big_t m);
        big_t rm, r2;
        rm = (big_t'(1) << W) % m;
        r2 = (big_t'(1) << (2 * W)) % m;
        mod_l = m;
        bus_l.ladder    = ld;
        bus_l.in_x      = x[W-1:0];
        bus_l.in_e      = e[EW-1:0];
        bus_l.in_elen   = LW'(elen);
        bus_l.in_m      = m[W-1:0];
        bus_l.in_rmodm  = rm[W-1:0];
        bus_l.in_r2modm = r2[W-1:0];
    endtask

    task automatic run_l(input bit ld, input big_t x, input big_t e, input int elen,
                         input big_t m, output big_t res, output int cyc, output bit ok);
        @(negedge clk);
        drive_l(ld, x, e, elen, m);
        bus_l.start = 1'b1;
        mcnt_l = 0;
        @(negedge clk);
        bus_l.start = 1'b0;
        cyc = 1;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (bus_l.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        res = big_t'(bus_l.result);
    endtask

    task automatic run_s(input bit ld, input big_t x, input big_t e, input int elen,
                         input big_t m, output big_t res, output bit ok);
        big_t rm, r2;
        rm = (big_t'(1) << SW) % m;
        r2 = (big_t'(1) << (2 * SW)) % m;
        mod_s = m;
        @(negedge clk);
        bus_s.ladder    = ld;
        bus_s.in_x      = x[SW-1:0];
        bus_s.in_e      = e[SEW-1:0];
        bus_s.in_elen   = SLW'(elen);
        bus_s.in_m      = m[SW-1:0];
        bus_s.in_rmodm  = rm[SW-1:0];
        bus_s.in_r2modm = r2[SW-1:0];
        bus_s.start = 1'b1;
        mcnt_s = 0;
        @(negedge clk);
        bus_s.start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (bus_s.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        res = big_t'(bus_s.result);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks += 6;
        if (bus_l.busy !== 1'b0) begin n_fails++; $display("FAIL rst_busy: got %b want 0", bus_l.busy); end
        if (bus_l.done !== 1'b0) begin n_fails++; $display("FAIL rst_done: got %b want 0", bus_l.done); end
        if (bus_l.mul_start !== 1'b0) begin
            n_fails++; $display("FAIL rst_mul_start: got %b want 0", bus_l.mul_start);
        end
        if (bus_l.result !== '0) begin n_fails++; $display("FAIL rst_result: got %h want 0", bus_l.result); end
        if (bus_l.mul_a !== '0) begin n_fails++; $display("FAIL rst_mul_a: got %h want 0", bus_l.mul_a); end
        if (bus_s.mul_b !== '0 || bus_s.busy !== 1'b0) begin
            n_fails++; $display("FAIL rst_small: got mul_b %h busy %b want 0", bus_s.mul_b, bus_s.busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_vectors;
        big_t x, e, m, res, exp_r;
        int   elen, cyc, exp_n;
        bit   ok;
        for (int v = 0; v < 3; v++) begin
            m = rand_mod(W);
            x = rand_big(W) % m;
            e = rand_big(EW);
            if (v == 0) begin
                e[7:0] = 8'hb1;
                elen = 8;
            end else begin
                elen = int'($urandom_range(1, 24));
            end
            exp_r = mod_exp(x, e, elen, m);
            for (int ld = 0; ld < 2; ld++) begin
                run_l(ld[0], x, e, elen, m, res, cyc, ok);
                exp_n = (ld == 1) ? 2 + 2 * elen : 2 + elen + popcnt(e, elen);
                n_checks += 3;
                if (!ok) begin n_fails++; $display("FAIL vec_timeout: v%0d ladder %0d no done", v, ld); end
                if (res !== exp_r) begin
                    n_fails++; $display("FAIL vec_result: v%0d ladder %0d got %h want %h", v, ld, res, exp_r);
                end
                if (mcnt_l != exp_n) begin
                    n_fails++; $display("FAIL vec_mulcount: v%0d ladder %0d got %0d want %0d", v, ld, mcnt_l, exp_n);
                end
            end
        end
    endtask

    task automatic test_small;
        big_t res, x, e, m, exp_r;
        bit   ok;
        for (int ld = 0; ld < 2; ld++) begin
            run_s(ld[0], big_t'(5), big_t'(3), 2, big_t'(23), res, ok);
            n_checks += 2;
            if (!ok || res !== big_t'(10)) begin
                n_fails++; $display("FAIL small_5e3: ladder %0d got %0d want 10", ld, res);
            end
            if (mcnt_s != ((ld == 1) ? 6 : 6)) begin
                n_fails++; $display("FAIL small_5e3_count: ladder %0d got %0d want 6", ld, mcnt_s);
            end
            run_s(ld[0], big_t'(5), big_t'(3), 0, big_t'(23), res, ok);
            n_checks += 2;
            if (!ok || res !== big_t'(1)) begin
                n_fails++; $display("FAIL small_elen0: ladder %0d got %0d want 1", ld, res);
            end
            if (mcnt_s != 2) begin
                n_fails++; $display("FAIL small_elen0_count: ladder %0d got %0d want 2", ld, mcnt_s);
            end
        end
        // elen beyond the exponent register is treated as the full register width
        for (int v = 0; v < 4; v++) begin
            m = rand_mod(SW);
            x = rand_big(SW) % m;
            e = rand_big(SEW);
            exp_r = mod_exp(x, e, 16, m);
            run_s(v[0], x, e, 31, m, res, ok);
            n_checks++;
            if (!ok || res !== exp_r) begin
                n_fails++; $display("FAIL small_clamp: v%0d got %0d want %0d", v, res, exp_r);
            end
        end
    endtask

    task automatic test_fixed_latency;
        big_t x, m, res0, res1;
        int   cyc0, cyc1;
        bit   ok0, ok1;
        lat_fixed = 5;
        m = rand_mod(W);
        x = rand_big(W) % m;
        run_l(1'b1, x, big_t'(0), 8, m, res0, cyc0, ok0);
        run_l(1'b1, x, big_t'(8'hff), 8, m, res1, cyc1, ok1);
        lat_fixed = 0;
        n_checks += 4;
        if (cyc0 != cyc1) begin n_fails++; $display("FAIL ladder_const_time: e=0 %0d cycles, e=ff %0d", cyc0, cyc1); end
        if (cyc0 != 1 + 18 * 6) begin n_fails++; $display("FAIL ladder_latency: got %0d want %0d", cyc0, 1 + 18 * 6); end
        if (!ok0 || res0 !== big_t'(1)) begin n_fails++; $display("FAIL ladder_e0: got %h want 1", res0); end
        if (!ok1 || res1 !== mod_exp(x, big_t'(8'hff), 8, m)) begin
            n_fails++; $display("FAIL ladder_eff: got %h", res1);
        end
    endtask

    task automatic test_busy_ignore;
        big_t x, e, m, res, exp_r, held;
        int   cyc, cnt;
        bit   ok;
        m = rand_mod(W);
        x = rand_big(W) % m;
        e = rand_big(EW);
        exp_r = mod_exp(x, e, 10, m);
        fork
            run_l(1'b0, x, e, 10, m, res, cyc, ok);
            begin
                repeat (12) @(negedge clk);
                bus_l.in_x   = ~bus_l.in_x;
                bus_l.in_e   = ~bus_l.in_e;
                bus_l.ladder = 1'b1;
                bus_l.start  = 1'b1;
                @(negedge clk);
                bus_l.start  = 1'b0;
            end
        join
        n_checks += 2;
        if (!ok || res !== exp_r) begin n_fails++; $display("FAIL busy_start_result: got %h want %h", res, exp_r); end
        if (mcnt_l != 2 + 10 + popcnt(e, 10)) begin
            n_fails++; $display("FAIL busy_start_count: got %0d want %0d", mcnt_l, 2 + 10 + popcnt(e, 10));
        end
        held = big_t'(bus_l.result);
        cnt = mcnt_l;
        @(negedge clk);
        bus_l.mul_result = ~bus_l.mul_result;
        bus_l.mul_done = 1'b1;
        @(negedge clk);
        bus_l.mul_done = 1'b0;
        repeat (5) @(negedge clk);
        n_checks += 2;
        if (big_t'(bus_l.result) !== held || bus_l.done !== 1'b0) begin
            n_fails++; $display("FAIL idle_mul_done: result %h done %b want %h 0", bus_l.result, bus_l.done, held);
        end
        if (mcnt_l != cnt || bus_l.busy !== 1'b0) begin
            n_fails++; $display("FAIL idle_mul_done_activity: muls %0d busy %b want %0d 0", mcnt_l, bus_l.busy, cnt);
        end
    endtask

    task automatic test_reset_mid;
        big_t x, e, m, res, exp_r;
        int   cyc;
        bit   ok, hit;
        m = rand_mod(W);
        x = rand_big(W) % m;
        e = rand_big(EW);
        @(negedge clk);
        drive_l(1'b1, x, e, 20, m);
        bus_l.start = 1'b1;
        mcnt_l = 0;
        @(negedge clk);
        bus_l.start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (mcnt_l >= 5) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (!hit) begin n_fails++; $display("FAIL reset_mid_progress: got %0d muls want 5", mcnt_l); end
        if (bus_l.busy !== 1'b0 || bus_l.done !== 1'b0 || bus_l.mul_start !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid_outputs: busy %b done %b mul_start %b want 0 0 0",
                     bus_l.busy, bus_l.done, bus_l.mul_start);
        end
        reset = 1'b0;
        repeat (25) @(negedge clk);
        exp_r = mod_exp(x, e, 20, m);
        run_l(1'b0, x, e, 20, m, res, cyc, ok);
        n_checks++;
        if (!ok || res !== exp_r) begin n_fails++; $display("FAIL reset_mid_rerun: got %h want %h", res, exp_r); end
    endtask

    initial begin
        bus_l.start = 1'b0; bus_l.ladder = 1'b0; bus_l.in_x = '0; bus_l.in_e = '0;
        bus_l.in_elen = '0; bus_l.in_m = '0; bus_l.in_rmodm = '0; bus_l.in_r2modm = '0;
        bus_l.mul_done = 1'b0; bus_l.mul_result = '0;
        bus_s.start = 1'b0; bus_s.ladder = 1'b0; bus_s.in_x = '0; bus_s.in_e = '0;
        bus_s.in_elen = '0; bus_s.in_m = '0; bus_s.in_rmodm = '0; bus_s.in_r2modm = '0;
        bus_s.mul_done = 1'b0; bus_s.mul_result = '0;
        test_reset();
        test_vectors();
        test_small();
        test_fixed_latency();
        test_busy_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
